// File: rtl/pwm_fault_guard.sv
// Gate-drive protection stage: passes complementary PWM to the pins, trips on
// external fault or shoot-through, and latches until a clear handshake plus a clean hold.
`timescale 1ns/1ps

module pwm_fault_guard #(
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned CLR_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwm_a_in,
    input  logic       pwm_b_in,
    input  logic       fault_n,
    input  logic       enable,
    input  logic       trip_clear,
    output logic       pwm_a_out,
    output logic       pwm_b_out,
    output logic       tripped,
    output logic [1:0] trip_cause,
    output logic [7:0] trip_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_TRIP     = 2'd2,
        ST_CLEARING = 2'd3
    } state_t;

    localparam logic [3:0] FILT_MAX  = 4'(FILT_CYC);
    localparam logic [3:0] FILT_LAST = 4'(FILT_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CLR_HOLD - 1);

    state_t     state_q, state_d;
    logic       fault_meta_q, fault_meta_d;
    logic       fault_s_q, fault_s_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       pwm_a_out_q, pwm_a_out_d;
    logic       pwm_b_out_q, pwm_b_out_d;
    logic       tripped_q, tripped_d;
    logic [1:0] trip_cause_q, trip_cause_d;
    logic [7:0] trip_count_q, trip_count_d;

    logic fault_det;
    logic shoot;
    logic clean;
    logic trip_entry;
    logic pass;

    // Fault synchroniser, glitch filter and shoot-through / clean-cycle decode
    always_comb begin
        fault_meta_d = fault_n;
        fault_s_d    = fault_meta_q;
        if (fault_s_q) begin
            filt_cnt_d = 4'd0;
        end else if (filt_cnt_q == FILT_MAX) begin
            filt_cnt_d = filt_cnt_q;
        end else begin
            filt_cnt_d = filt_cnt_q + 4'd1;
        end
        fault_det = (!fault_s_q && (filt_cnt_q == FILT_LAST)) || (filt_cnt_q == FILT_MAX);
        shoot     = (state_q == ST_RUN) && pwm_a_in && pwm_b_in;
        clean     = fault_s_q && !pwm_a_in && !pwm_b_in;
    end

    // Next-state logic and clear-hold counter
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = 8'd0;
        case (state_q)
            ST_IDLE: begin
                if (fault_det) begin
                    state_d = ST_TRIP;
                end else if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fault_det || shoot) begin
                    state_d = ST_TRIP;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TRIP: begin
                if (trip_clear && fault_s_q) begin
                    state_d = ST_CLEARING;
                end else begin
                    state_d = ST_TRIP;
                end
            end
            ST_CLEARING: begin
                if (fault_det) begin
                    state_d = ST_TRIP;
                end else if (clean) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end else begin
                    hold_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Trip bookkeeping and the registered pin drive
    always_comb begin
        trip_entry = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && (state_d == ST_TRIP);
        if (trip_entry) begin
            trip_cause_d = {shoot, fault_det};
        end else if (state_d == ST_IDLE) begin
            trip_cause_d = 2'b00;
        end else begin
            trip_cause_d = trip_cause_q;
        end
        if (trip_entry && (trip_count_q != 8'd255)) begin
            trip_count_d = trip_count_q + 8'd1;
        end else begin
            trip_count_d = trip_count_q;
        end
        // Overlap is masked as well, so an IDLE->RUN entry with A=B=1 cannot reach the pins
        pass        = (state_d == ST_RUN) && !(pwm_a_in && pwm_b_in);
        pwm_a_out_d = pass && pwm_a_in;
        pwm_b_out_d = pass && pwm_b_in;
        tripped_d   = (state_d == ST_TRIP) || (state_d == ST_CLEARING);
    end

    // State and output registers; synchroniser resets to the inactive level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fault_meta_q <= 1'b1;
            fault_s_q    <= 1'b1;
            filt_cnt_q   <= 4'd0;
            hold_cnt_q   <= 8'd0;
            pwm_a_out_q  <= 1'b0;
            pwm_b_out_q  <= 1'b0;
            tripped_q    <= 1'b0;
            trip_cause_q <= 2'b00;
            trip_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            fault_meta_q <= fault_meta_d;
            fault_s_q    <= fault_s_d;
            filt_cnt_q   <= filt_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            pwm_a_out_q  <= pwm_a_out_d;
            pwm_b_out_q  <= pwm_b_out_d;
            tripped_q    <= tripped_d;
            trip_cause_q <= trip_cause_d;
            trip_count_q <= trip_count_d;
        end
    end

    assign pwm_a_out  = pwm_a_out_q;
    assign pwm_b_out  = pwm_b_out_q;
    assign tripped    = tripped_q;
    assign trip_cause = trip_cause_q;
    assign trip_count = trip_count_q;

endmodule
